decode_issue: RTL
=================

// Module: decode_issue
// PURPOSE
//  Decode/issue stage between fetch and execute. Registers one 32-bit instruction
//  and splits it into op/func/register/immediate fields plus class flags.
//  A per-register scoreboard (int and FP banks) stalls issue on RAW/WAW hazards
//  against in-flight long-latency ops (MULT, DIV, configurable FPU subset).
//  Valid/ready on both sides; 1-cycle latency; flush from branch resolution.
// PARAMETERS
//  XLEN          32             immediate output width (sign-extended)
//  REG_ADDR_W    6              register index width; inst fields rd/rs/rt use it
//  PC_W          15             pc width carried alongside instruction
//  LONG_FPU_MASK 16'b0000_0011_0001_1111  bit f set => FPU func f is long-latency
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous reset, active high
//  in_valid   in   1           fetch offers instruction
//  in_ready   out  1           stage accepts (combinational)
//  in_inst    in   32          op=[31:28] rd=[27:22] rs=[21:16] rt=[15:10] func=[3:0] imm=[15:0]
//  in_pc      in   PC_W        pc of in_inst
//  out_valid  out  1           decoded instruction held
//  out_ready  in   1           execute consumes
//  out_op     out  4           opcode
//  out_func   out  4           func (SPECIAL/FPU), else 0
//  out_rd/rs/rt out REG_ADDR_W register indices
//  out_rd_fp/rs_fp/rt_fp out 1 bank of each index (1 = FP file)
//  out_imm    out  XLEN        sign-extended inst[15:0]
//  out_pc     out  PC_W        pc of held instruction
//  out_long   out  1           long-latency op; scoreboard bit set for rd
//  out_illegal out 1           undefined func code
//  wb_valid   in   1           long-op writeback completes
//  wb_fp      in   1           writeback bank
//  wb_addr    in   REG_ADDR_W  writeback register
//  flush      in   1           discard held + offered instruction
// BEHAVIOUR
//  Reset: out_valid=0, all out_* fields 0, scoreboard all clear.
//  Banks: rd FP for FPU(!FTOI), LW_S; rs FP for FPU(!ITOF), BEQ_S, BLE_S;
//   rt FP for FPU, SW_S, BEQ_S, BLE_S; all others int.
//  Long: SPECIAL with MULT/DIV; FPU with LONG_FPU_MASK[func]=1. Illegal is never long.
//  Illegal: SPECIAL func 0110/1011/1101; FPU func 0110 or 1010..1110. Passed on, flagged.
//  hazard = pend[rs_bank][rs] | pend[rt_bank][rt] | pend[rd_bank][rd] (unused fields
//   checked too; conservative stalls accepted).
//  in_ready = (!out_valid | out_ready) & !hazard(in_inst) & !flush.
//  Accept (in_valid&in_ready): out_* load decoded fields next edge, out_valid=1.
//  out_ready & out_valid & no accept: out_valid=0 next edge; fields hold.
//  out_valid & !out_ready: all out_* stable until consumed.
//  Scoreboard set on accept of long op: pend[rd_bank][rd]<=1.
//  wb_valid clears pend[wb_fp][wb_addr]. Same bit set and cleared in one cycle: set wins.
//  Writeback in cycle N makes dependent in_ready rise in cycle N+1 (no bypass).
//  flush: out_valid=0 next edge, no accept that cycle; scoreboard untouched
//   (in-flight ops still write back). flush dominates in_valid and out_ready.
//  wb_valid on a clear bit: no effect. rst mid-operation clears everything.
// TESTING
//  Back-to-back ADDI x1,x2,5 / ADDI x3,x4,-1 with out_ready=1 -> one issue per cycle,
//   out_imm=0x00000005 then 0xFFFFFFFF, 1-cycle latency.
//  FPU MUL f3 then FPU ADD f4,f3,f5 -> second stalls (in_ready=0) until wb_valid
//   fp=1 addr=3; in_ready rises cycle after wb.
//  FPU FTOI x7,f2 then ADDI x8,x7,1 -> int bank bit 7 stalls ADDI; FP bit 7 unaffected.
//  out_ready=0 for 3 cycles with held LW -> out_* unchanged, in_ready=0; resumes on ready.
//  Long DIV x9 accepted same cycle wb_valid clears x9 -> pend x9 remains 1.
//  flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, nothing accepted;
//   SPECIAL func 1101 -> out_illegal=1, out_long=0.

Source files
------------

// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage between fetch and execute.
//
// Registers one 32-bit instruction per handshake, splits it into opcode,
// func, register indices and a sign-extended immediate, and tags it with
// register-bank, long-latency and illegal flags. A two-bank scoreboard
// (int / FP) records destinations of in-flight long-latency ops and holds
// off any instruction that names one of them until its writeback.
//
// Instruction format:
//   op=[31:28] rd=[27:22] rs=[21:16] rt=[15:10] func=[3:0] imm=[15:0]
// Opcode map:
//   0 SPECIAL  1 FPU  2 ADDI  3 LW  4 SW  5 LW_S  6 SW_S  7 BEQ
//   8 BEQ_S    9 BLE_S   10..15 other integer ops
// SPECIAL func: 8 MULT, 9 DIV; 6/B/D undefined.
// FPU func: 0 ADD 1 SUB 2 MUL 3 DIV 4 SQRT 5 ABS 7 NEG 8 ITOF 9 FTOI F MOV;
//   6 and A..E undefined.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        fetch handshake (in_ready is combinational)
//   in_inst, in_pc           offered instruction and its pc
//   out_valid/out_ready      execute handshake
//   out_op, out_func         opcode; func for SPECIAL/FPU, else 0
//   out_rd/rs/rt, *_fp       register indices and bank (1 = FP)
//   out_imm, out_pc          sign-extended inst[15:0], pc
//   out_long, out_illegal    long-latency op / undefined func
//   wb_valid, wb_fp, wb_addr long-op writeback clears scoreboard bit
//   flush                    drop held and offered instruction
module decode_issue #(
    parameter int          XLEN          = 32,
    parameter int          REG_ADDR_W    = 6,
    parameter int          PC_W          = 15,
    parameter logic [15:0] LONG_FPU_MASK = 16'b0000_0011_0001_1111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [PC_W-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_op,
    output logic [3:0]            out_func,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [REG_ADDR_W-1:0] out_rs,
    output logic [REG_ADDR_W-1:0] out_rt,
    output logic                  out_rd_fp,
    output logic                  out_rs_fp,
    output logic                  out_rt_fp,
    output logic [XLEN-1:0]       out_imm,
    output logic [PC_W-1:0]       out_pc,
    output logic                  out_long,
    output logic                  out_illegal,
    input  logic                  wb_valid,
    input  logic                  wb_fp,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic                  flush
);

    localparam int NREG = 1 << REG_ADDR_W;
    localparam logic [NREG-1:0] SB_ONE = NREG'(1);

    localparam logic [3:0] OP_SPECIAL = 4'd0;
    localparam logic [3:0] OP_FPU     = 4'd1;
    localparam logic [3:0] OP_LW_S    = 4'd5;
    localparam logic [3:0] OP_SW_S    = 4'd6;
    localparam logic [3:0] OP_BEQ_S   = 4'd8;
    localparam logic [3:0] OP_BLE_S   = 4'd9;

    localparam logic [3:0] SP_MULT  = 4'h8;
    localparam logic [3:0] SP_DIV   = 4'h9;
    localparam logic [3:0] FP_ITOF  = 4'h8;
    localparam logic [3:0] FP_FTOI  = 4'h9;

    // ------------------------------------------------------------------
    // Field extraction and classification of the offered instruction
    // ------------------------------------------------------------------
    logic [3:0]            w_op;
    logic [3:0]            w_func_raw;
    logic [3:0]            w_func;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [XLEN-1:0]       w_imm;
    logic                  w_special;
    logic                  w_fpu;
    logic                  w_rd_fp;
    logic                  w_rs_fp;
    logic                  w_rt_fp;
    logic                  w_illegal;
    logic                  w_long;

    assign w_op       = in_inst[31:28];
    assign w_rd       = in_inst[22 +: REG_ADDR_W];
    assign w_rs       = in_inst[16 +: REG_ADDR_W];
    assign w_rt       = in_inst[10 +: REG_ADDR_W];
    assign w_func_raw = in_inst[3:0];
    assign w_imm      = {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
    assign w_special  = (w_op == OP_SPECIAL);
    assign w_fpu      = (w_op == OP_FPU);
    assign w_func     = (w_special || w_fpu) ? w_func_raw : 4'd0;

    always_comb begin
        w_rd_fp   = 1'b0;
        w_rs_fp   = 1'b0;
        w_rt_fp   = 1'b0;
        w_illegal = 1'b0;
        w_long    = 1'b0;
        unique case (w_op)
            OP_SPECIAL: begin
                w_illegal = (w_func_raw == 4'h6) || (w_func_raw == 4'hB) ||
                            (w_func_raw == 4'hD);
                w_long    = (w_func_raw == SP_MULT) || (w_func_raw == SP_DIV);
            end
            OP_FPU: begin
                w_rd_fp   = (w_func_raw != FP_FTOI);
                w_rs_fp   = (w_func_raw != FP_ITOF);
                w_rt_fp   = 1'b1;
                w_illegal = (w_func_raw == 4'h6) ||
                            ((w_func_raw >= 4'hA) && (w_func_raw <= 4'hE));
                // An undefined func must never reserve a register.
                w_long    = LONG_FPU_MASK[w_func_raw] && !w_illegal;
            end
            OP_LW_S:  w_rd_fp = 1'b1;
            OP_SW_S:  w_rt_fp = 1'b1;
            OP_BEQ_S, OP_BLE_S: begin
                w_rs_fp = 1'b1;
                w_rt_fp = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard and handshake
    // ------------------------------------------------------------------
    logic [NREG-1:0] r_pend_int;
    logic [NREG-1:0] r_pend_fp;
    logic            w_haz_rd;
    logic            w_haz_rs;
    logic            w_haz_rt;
    logic            w_hazard;
    logic            w_accept;
    logic [NREG-1:0] w_set_int;
    logic [NREG-1:0] w_set_fp;
    logic [NREG-1:0] w_clr_int;
    logic [NREG-1:0] w_clr_fp;
    logic            r_valid;

    // Every field is checked against its bank even if the opcode ignores it;
    // the occasional extra stall is cheaper than per-opcode usage decode.
    assign w_haz_rd = w_rd_fp ? r_pend_fp[w_rd] : r_pend_int[w_rd];
    assign w_haz_rs = w_rs_fp ? r_pend_fp[w_rs] : r_pend_int[w_rs];
    assign w_haz_rt = w_rt_fp ? r_pend_fp[w_rt] : r_pend_int[w_rt];
    assign w_hazard = w_haz_rd | w_haz_rs | w_haz_rt;

    assign in_ready = (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_accept = in_valid && in_ready;

    assign w_set_int = (w_accept && w_long && !w_rd_fp) ? (SB_ONE << w_rd) : '0;
    assign w_set_fp  = (w_accept && w_long &&  w_rd_fp) ? (SB_ONE << w_rd) : '0;
    assign w_clr_int = (wb_valid && !wb_fp) ? (SB_ONE << wb_addr) : '0;
    assign w_clr_fp  = (wb_valid &&  wb_fp) ? (SB_ONE << wb_addr) : '0;

    // Set is applied after clear so a new reservation survives a writeback
    // to the same register in the same cycle. Flush leaves the scoreboard
    // alone: ops already in execute will still write back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_int <= '0;
            r_pend_fp  <= '0;
        end else begin
            r_pend_int <= (r_pend_int & ~w_clr_int) | w_set_int;
            r_pend_fp  <= (r_pend_fp  & ~w_clr_fp)  | w_set_fp;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [3:0]            r_op;
    logic [3:0]            r_func;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic                  r_rd_fp;
    logic                  r_rs_fp;
    logic                  r_rt_fp;
    logic [XLEN-1:0]       r_imm;
    logic [PC_W-1:0]       r_pc;
    logic                  r_long;
    logic                  r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Fields only move on accept, so they hold while stalled and after drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_func    <= '0;
            r_rd      <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd_fp   <= 1'b0;
            r_rs_fp   <= 1'b0;
            r_rt_fp   <= 1'b0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_long    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_op      <= w_op;
            r_func    <= w_func;
            r_rd      <= w_rd;
            r_rs      <= w_rs;
            r_rt      <= w_rt;
            r_rd_fp   <= w_rd_fp;
            r_rs_fp   <= w_rs_fp;
            r_rt_fp   <= w_rt_fp;
            r_imm     <= w_imm;
            r_pc      <= in_pc;
            r_long    <= w_long;
            r_illegal <= w_illegal;
        end
    end

    assign out_valid   = r_valid;
    assign out_op      = r_op;
    assign out_func    = r_func;
    assign out_rd      = r_rd;
    assign out_rs      = r_rs;
    assign out_rt      = r_rt;
    assign out_rd_fp   = r_rd_fp;
    assign out_rs_fp   = r_rs_fp;
    assign out_rt_fp   = r_rt_fp;
    assign out_imm     = r_imm;
    assign out_pc      = r_pc;
    assign out_long    = r_long;
    assign out_illegal = r_illegal;

endmodule
